// File: rtl/svd_sequencer.sv
// Sequencer for a 2x2 SVD core: loads a matrix as eight half-elements, waits for
// the core's completion pulse (or times out), then reads back eight S/UV byte pairs.
//
// state | meaning
// IDLE  | in_ready high, waiting for a matrix
// LOAD  | 8 write cycles, upper then lower 5 bits of each element
// WAIT  | waiting for a core_ready rising edge, bounded by WAIT_MAX cycles
// READ  | 8 output-enable cycles, one S/UV byte pair captured per cycle
// DONE  | result (or timeout) presented until out_ready
module svd_sequencer #(
  parameter int WAIT_MAX = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [39:0] mat_in,
  output logic        core_we,
  output logic        core_oe,
  output logic [1:0]  core_sel,
  output logic [4:0]  core_data,
  input  logic        core_ready,
  input  logic [6:0]  core_s,
  input  logic [7:0]  core_uv,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [55:0] s_out,
  output logic [63:0] uv_out,
  output logic        err
);

  localparam int TW = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    WAIT = 3'd2,
    READ = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [39:0]   mat_q, mat_d;
  logic          ready_q;
  logic          rise;
  logic [9:0]    elem;

  logic          in_ready_d, out_valid_d, err_d, core_we_d, core_oe_d;
  logic [1:0]    core_sel_d;
  logic [4:0]    core_data_d;
  logic [55:0]   s_d;
  logic [63:0]   uv_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    mat_d   = mat_q;
    s_d     = s_out;
    uv_d    = uv_out;
    err_d   = err;
    rise    = core_ready & ~ready_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = LOAD;
          mat_d   = mat_in;
          idx_d   = 3'd0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (idx_q == 3'd7) begin
          state_d = WAIT;
          idx_d   = 3'd0;
          tmr_d   = TW'(WAIT_MAX - 1);
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      WAIT: begin
        // a completion pulse wins over a simultaneous terminal count
        if (rise) begin
          state_d = READ;
          idx_d   = 3'd0;
        end else if (tmr_q == '0) begin
          state_d = DONE;
          err_d   = 1'b1;
          s_d     = '0;
          uv_d    = '0;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      READ: begin
        for (int r = 0; r < 8; r++) begin
          if (idx_q == 3'(r)) begin
            s_d[7*r +: 7]  = core_s;
            uv_d[8*r +: 8] = core_uv;
          end
        end
        if (idx_q == 3'd7) begin
          state_d = DONE;
          idx_d   = 3'd0;
          err_d   = 1'b0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // outputs are registered, so they are derived from the next state
    case (idx_d[2:1])
      2'd0:    elem = mat_d[9:0];
      2'd1:    elem = mat_d[19:10];
      2'd2:    elem = mat_d[29:20];
      default: elem = mat_d[39:30];
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    core_we_d   = (state_d == LOAD);
    core_oe_d   = (state_d == READ);
    core_sel_d  = (state_d == LOAD || state_d == READ) ? idx_d[2:1] : 2'd0;
    core_data_d = (state_d == LOAD) ? (idx_d[0] ? elem[4:0] : elem[9:5]) : 5'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      tmr_q     <= '0;
      mat_q     <= '0;
      ready_q   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      err       <= 1'b0;
      core_we   <= 1'b0;
      core_oe   <= 1'b0;
      core_sel  <= 2'd0;
      core_data <= 5'd0;
      s_out     <= '0;
      uv_out    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tmr_q     <= tmr_d;
      mat_q     <= mat_d;
      ready_q   <= core_ready;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      err       <= err_d;
      core_we   <= core_we_d;
      core_oe   <= core_oe_d;
      core_sel  <= core_sel_d;
      core_data <= core_data_d;
      s_out     <= s_d;
      uv_out    <= uv_d;
    end
  end

endmodule

// File: tb/tb_svd_sequencer.sv
// Bench for svd_sequencer: a default-parameter instance for the data path and a
// WAIT_MAX=16 instance for the timeout path, both checked against a spec-level model.
module tb_svd_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_valid_t;
  logic [39:0] mat_in;
  logic        core_ready, core_ready_t;
  logic [6:0]  core_s;
  logic [7:0]  core_uv;
  logic        out_ready, out_ready_t;

  logic        in_ready, core_we, core_oe, out_valid, err;
  logic [1:0]  core_sel;
  logic [4:0]  core_data;
  logic [55:0] s_out;
  logic [63:0] uv_out;

  logic        in_ready_t, core_we_t, core_oe_t, out_valid_t, err_t;
  logic [1:0]  core_sel_t;
  logic [4:0]  core_data_t;
  logic [55:0] s_out_t;
  logic [63:0] uv_out_t;

  int n_chk  = 0;
  int n_pass = 0;

  logic [6:0] exp_s  [8];
  logic [7:0] exp_uv [8];

  svd_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mat_in(mat_in),
    .core_we(core_we), .core_oe(core_oe), .core_sel(core_sel), .core_data(core_data),
    .core_ready(core_ready), .core_s(core_s), .core_uv(core_uv),
    .out_valid(out_valid), .out_ready(out_ready), .s_out(s_out), .uv_out(uv_out), .err(err)
  );

  svd_sequencer #(.WAIT_MAX(16)) dut_t (
    .clk(clk), .rst(rst), .in_valid(in_valid_t), .in_ready(in_ready_t), .mat_in(mat_in),
    .core_we(core_we_t), .core_oe(core_oe_t), .core_sel(core_sel_t), .core_data(core_data_t),
    .core_ready(core_ready_t), .core_s(core_s), .core_uv(core_uv),
    .out_valid(out_valid_t), .out_ready(out_ready_t), .s_out(s_out_t), .uv_out(uv_out_t),
    .err(err_t)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // half-element i of the matrix: upper 5 bits for even i, lower 5 for odd i
  function automatic logic [4:0] exp_half(input logic [39:0] m, input int i);
    logic [39:0] sh;
    sh = m >> (10 * (i / 2));
    return (i % 2 == 0) ? sh[9:5] : sh[4:0];
  endfunction

  function automatic logic [55:0] pack_s();
    logic [55:0] v;
    for (int r = 0; r < 8; r++) v[7*r +: 7] = exp_s[r];
    return v;
  endfunction

  function automatic logic [63:0] pack_uv();
    logic [63:0] v;
    for (int r = 0; r < 8; r++) v[8*r +: 8] = exp_uv[r];
    return v;
  endfunction

  function automatic logic [39:0] rand_mat();
    return {8'($urandom), $urandom};
  endfunction

  task automatic run_txn(input logic [39:0] m, input int dly, input bit fixed, input int hold);
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    mat_in   = m;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      mat_in    = rand_mat();
      chk("load_we", 64'(core_we), 64'd1);
      chk("load_oe", 64'(core_oe), 64'd0);
      chk("load_sel", 64'(core_sel), 64'(i / 2));
      chk("load_data", 64'(core_data), 64'(exp_half(m, i)));
      chk("load_in_ready", 64'(in_ready), 64'd0);
    end
    for (int k = 1; k <= dly; k++) begin
      @(negedge clk);
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      chk("wait_we", 64'(core_we), 64'd0);
      chk("wait_oe", 64'(core_oe), 64'd0);
      chk("wait_sel", 64'(core_sel), 64'd0);
      chk("wait_data", 64'(core_data), 64'd0);
      chk("wait_valid", 64'(out_valid), 64'd0);
      if (k == dly) begin
        core_ready = 1'b1;
        out_ready  = 1'b0;
      end
    end
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      exp_s[r]  = fixed ? 7'(8'h10 + r) : 7'($urandom);
      exp_uv[r] = fixed ? 8'(8'hA0 + r) : 8'($urandom);
      core_s    = exp_s[r];
      core_uv   = exp_uv[r];
      in_valid  = 1'($urandom);
      chk("read_oe", 64'(core_oe), 64'd1);
      chk("read_we", 64'(core_we), 64'd0);
      chk("read_sel", 64'(core_sel), 64'(r / 2));
      chk("read_valid", 64'(out_valid), 64'd0);
    end
    @(negedge clk);
    core_ready = 1'b0;
    core_s     = 7'($urandom);
    core_uv    = 8'($urandom);
    for (int h = 0; h < hold; h++) begin
      if (h > 0) @(negedge clk);
      in_valid = 1'($urandom);
      chk("done_valid", 64'(out_valid), 64'd1);
      chk("done_err", 64'(err), 64'd0);
      chk("done_s", 64'(s_out), 64'(pack_s()));
      chk("done_uv", uv_out, pack_uv());
      chk("done_in_ready", 64'(in_ready), 64'd0);
      chk("done_oe", 64'(core_oe), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("ret_in_ready", 64'(in_ready), 64'd1);
    chk("ret_valid", 64'(out_valid), 64'd0);
  endtask

  task automatic run_timeout(input bit rdy_high);
    @(negedge clk);
    core_ready_t = rdy_high;
    mat_in       = rand_mat();
    in_valid_t   = 1'b1;
    @(negedge clk);
    in_valid_t = 1'b0;
    chk("to_load_we", 64'(core_we_t), 64'd1);
    for (int i = 1; i < 8; i++) @(negedge clk);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("to_wait_valid", 64'(out_valid_t), 64'd0);
      chk("to_wait_oe", 64'(core_oe_t), 64'd0);
    end
    @(negedge clk);
    chk("to_valid", 64'(out_valid_t), 64'd1);
    chk("to_err", 64'(err_t), 64'd1);
    chk("to_s", 64'(s_out_t), 64'd0);
    chk("to_uv", uv_out_t, 64'd0);
    chk("to_oe", 64'(core_oe_t), 64'd0);
    out_ready_t = 1'b1;
    @(negedge clk);
    out_ready_t  = 1'b0;
    core_ready_t = 1'b0;
    chk("to_ret_in_ready", 64'(in_ready_t), 64'd1);
  endtask

  initial begin
    logic [39:0] m;
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_valid_t   = 1'b0;
    mat_in       = '0;
    core_ready   = 1'b0;
    core_ready_t = 1'b0;
    core_s       = '0;
    core_uv      = '0;
    out_ready    = 1'b0;
    out_ready_t  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_we", 64'(core_we), 64'd0);
    chk("rst_oe", 64'(core_oe), 64'd0);
    chk("rst_sel", 64'(core_sel), 64'd0);
    chk("rst_data", 64'(core_data), 64'd0);
    chk("rst_s", 64'(s_out), 64'd0);
    chk("rst_uv", uv_out, 64'd0);
    rst = 1'b0;

    run_txn({10'h000, 10'h3FF, 10'h0AA, 10'h155}, 20, 1'b1, 5);

    for (int t = 0; t < 6; t++)
      run_txn(rand_mat(), int'($urandom_range(1, 40)), 1'b0, int'($urandom_range(1, 4)));

    // reset during the fourth LOAD cycle
    m = rand_mat();
    @(negedge clk);
    mat_in   = m;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rl_we", 64'(core_we), 64'd1);
    repeat (3) @(negedge clk);
    chk("rl_sel4", 64'(core_sel), 64'd1);
    chk("rl_data4", 64'(core_data), 64'(exp_half(m, 3)));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rl_we_off", 64'(core_we), 64'd0);
    chk("rl_in_ready", 64'(in_ready), 64'd1);
    chk("rl_sel", 64'(core_sel), 64'd0);
    chk("rl_data", 64'(core_data), 64'd0);
    chk("rl_valid", 64'(out_valid), 64'd0);
    run_txn(rand_mat(), 7, 1'b0, 2);

    run_timeout(1'b0);
    run_timeout(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/svd_sequencer.md
SVD_SEQUENCER -- requirements
Module: svd_sequencer

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 4095: maximum cycles spent in WAIT before timeout.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  in  1  upstream matrix valid.
REQ-005 SHALL have port in_ready  out  1  block can accept a matrix.
REQ-006 SHALL have port mat_in  in  40  2x2 matrix; element k (0=a11,1=a12,2=a21,3=a22) at [10k+9:10k].
REQ-007 SHALL have port core_we  out  1  write enable to the SVD core.
REQ-008 SHALL have port core_oe  out  1  output enable to the SVD core.
REQ-009 SHALL have port core_sel  out  2  element select to the SVD core.
REQ-010 SHALL have port core_data  out  5  write data half-element to the SVD core.
REQ-011 SHALL have port core_ready  in  1  SVD core completion flag.
REQ-012 SHALL have port core_s  in  7  SVD core singular-value byte.
REQ-013 SHALL have port core_uv  in  8  SVD core U/V byte.
REQ-014 SHALL have port out_valid  out  1  result valid.
REQ-015 SHALL have port out_ready  in  1  downstream accepts result.
REQ-016 SHALL have port s_out  out  56  eight S bytes; byte r at [7r+6:7r].
REQ-017 SHALL have port uv_out  out  64  eight UV bytes; byte r at [8r+7:8r].
REQ-018 SHALL have port err  out  1  result is a timeout, not valid SVD data.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, WAIT, READ, DONE; all outputs registered.
REQ-020 SHALL assert in_ready only in IDLE; in_valid and in_ready high at an edge latches mat_in and moves to LOAD.
REQ-021 LOAD SHALL last exactly 8 cycles, index i=0..7: core_we=1, core_sel=i[2:1], core_data=element[core_sel] bits [9:5] when i[0]=0, bits [4:0] when i[0]=1.
REQ-022 After LOAD, SHALL enter WAIT with core_we=0, core_sel=0, core_data=0.
REQ-023 SHALL register core_ready every cycle; WAIT exits on a rising edge (current 1, registered previous 0), not on a level.
REQ-024 WAIT SHALL count cycles; reaching WAIT_MAX with no rising edge SHALL go to DONE with err=1, s_out=0, uv_out=0.
REQ-025 A rising edge SHALL move WAIT to READ on the next cycle; READ lasts exactly 8 cycles, index r=0..7: core_oe=1, core_sel=r[2:1].
REQ-026 In READ, at the edge closing cycle r, SHALL capture core_s into s_out byte r and core_uv into uv_out byte r.
REQ-027 After READ, SHALL enter DONE with core_oe=0, core_sel=0, out_valid=1, err=0.
REQ-028 In DONE, s_out, uv_out and err SHALL hold stable until out_valid and out_ready are both high at an edge, then return to IDLE next cycle.
REQ-029 Latency: accept edge T -> core_we high cycles T+1..T+8; core_ready edge sampled at E -> core_oe high cycles E+1..E+8, out_valid from E+9.
REQ-030 SHALL ignore in_valid outside IDLE and out_ready outside DONE.
REQ-031 core_we and core_oe SHALL never be high in the same cycle.

Reset
REQ-032 rst high at an edge SHALL force IDLE, in_ready=1, out_valid=0, err=0, core_we=0, core_oe=0, core_sel=0, core_data=0, s_out=0, uv_out=0, counters=0, registered core_ready=0, from any state including mid-LOAD or mid-READ.

Verification
REQ-033 mat_in a11=10'h155, a12=10'h0AA, a21=10'h3FF, a22=10'h000 -> core_data 0A,15,05,0A,1F,1F,00,00, core_sel 0,0,1,1,2,2,3,3, core_we high 8 cycles.
REQ-034 core_ready rises 20 cycles after LOAD; core model returns S=8'h10+r, UV=8'hA0+r -> s_out byte r=7'h10+r, uv_out byte r=8'hA0+r, out_valid at edge+9, err=0.
REQ-035 out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0; out_ready high -> IDLE next cycle, in_ready=1.
REQ-036 WAIT_MAX=16, core_ready never rises -> DONE after 16 WAIT cycles with err=1, s_out=0, uv_out=0.
REQ-037 core_ready already high on WAIT entry and stays high -> no READ; timeout path taken.
REQ-038 rst asserted on the 4th LOAD cycle -> next cycle core_we=0, state IDLE, in_ready=1; new matrix then loads normally from i=0.
